// File: rtl/rfphoenix_valu_sched_pkg.sv
// Shared types and sizing for the rfPhoenix vector-ALU issue scheduler.
package rfphoenix_valu_sched_pkg;

  localparam int VALU_NREQ  = 4;
  localparam int VALU_LAT   = 3;
  localparam int VALU_MAXIF = 2;
  localparam int VALU_TAGW  = 6;
  localparam int VALU_DW    = 128;
  localparam int VALU_TIDW  = $clog2(VALU_NREQ);

  typedef logic [39:0] instruction_t;

  typedef enum logic [1:0] {
    PRC8  = 2'd0,
    PRC16 = 2'd1,
    PRC32 = 2'd2,
    PRC64 = 2'd3
  } prec_t;

  typedef logic [VALU_DW-1:0]   vector_value_t;
  typedef logic [VALU_TIDW-1:0] valu_tid_t;
  typedef logic [VALU_TAGW-1:0] valu_tag_t;

  // One slot of the issue/result pipeline; data is only meaningful from S1 on.
  typedef struct packed {
    logic          v;
    valu_tid_t     tid;
    valu_tag_t     tag;
    instruction_t  ir;
    prec_t         prc;
    vector_value_t data;
  } valu_stage_t;

endpackage

// File: rtl/rfphoenix_valu_sched_if.sv
// Thread-issue, ALU and writeback signals of the shared vector-ALU scheduler.
interface rfphoenix_valu_sched_if
  import rfphoenix_valu_sched_pkg::*;
#(
  parameter int NREQ = VALU_NREQ,
  parameter int TAGW = VALU_TAGW
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  instruction_t            req_ir  [NREQ];
  prec_t                   req_prc [NREQ];
  logic [TAGW-1:0]         req_tag [NREQ];
  logic [NREQ-1:0]         flush;

  instruction_t            alu_ir;
  prec_t                   alu_prc;
  logic [$clog2(NREQ)-1:0] alu_tid;
  vector_value_t           alu_o;

  logic                    res_valid;
  logic                    res_ready;
  logic [$clog2(NREQ)-1:0] res_tid;
  logic [TAGW-1:0]         res_tag;
  vector_value_t           res_o;

  // Thread issue logic, ALU and writeback side.
  modport master (
    output req_valid, req_ir, req_prc, req_tag, flush, alu_o, res_ready,
    input  req_ready, alu_ir, alu_prc, alu_tid, res_valid, res_tid, res_tag, res_o
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_ir, req_prc, req_tag, flush, alu_o, res_ready,
    output req_ready, alu_ir, alu_prc, alu_tid, res_valid, res_tid, res_tag, res_o
  );

endinterface

// File: rtl/rfphoenix_valu_sched_chk.sv
// Credit-counter invariants of the vector-ALU scheduler.
module rfphoenix_valu_sched_chk #(
  parameter int NREQ  = 4,
  parameter int MAXIF = 2,
  parameter int CW    = 2
) (
  input logic                     clk,
  input logic                     rst,
  input logic [NREQ-1:0][CW-1:0]  cnt,
  input logic [NREQ-1:0]          gnt,
  input logic [NREQ-1:0]          retire,
  input logic [NREQ-1:0]          flush
);

  // Counters stay within 0..MAXIF: no grant past the limit, no retire from zero.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        assert (cnt[i] <= CW'(MAXIF));
        assert (flush[i] || !(retire[i] && !gnt[i] && (cnt[i] == CW'(0))));
        assert (flush[i] || !(gnt[i] && !retire[i] && (cnt[i] == CW'(MAXIF))));
      end
    end
  end

endmodule

// File: rtl/rfphoenix_valu_sched_rr_arb.sv
// N-wide round-robin arbiter: one-hot grant to the first request at or above
// the pointer (wrapping), pointer moves just past the winner on each grant.
module rfphoenix_rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Scan upward from the pointer and stop at the first active request.
  always_comb begin
    gnt     = '0;
    gnt_id  = ptr_r;
    found_s = 1'b0;
    idx_s   = ptr_r;
    for (int k = 0; k < N; k++) begin
      idx_s = ptr_r + IW'(k);
      if (en && !found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_id     = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign gnt_any = found_s;

  // Pointer advances past the winner on a grant and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= gnt_id + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/rfphoenix_valu_sched.sv
// Shares one rfPhoenix vector ALU among NREQ thread issue ports: round-robin
// issue into S0, rigid LAT-stage result pipe, per-thread credits and flush.
module rfphoenix_valu_sched
  import rfphoenix_valu_sched_pkg::*;
#(
  parameter int NREQ  = VALU_NREQ,
  parameter int LAT   = VALU_LAT,
  parameter int MAXIF = VALU_MAXIF,
  parameter int TAGW  = VALU_TAGW
) (
  input logic                  clk,
  input logic                  rst,
  rfphoenix_valu_sched_if.slave bus
);

  localparam int CW = $clog2(MAXIF + 1);

  valu_stage_t               st_r [LAT];
  valu_stage_t               st_s [LAT];
  logic [NREQ-1:0][CW-1:0]   cnt_r;
  logic [NREQ-1:0][CW-1:0]   cnt_s;

  logic                      en_s;
  logic                      retire_s;
  logic [NREQ-1:0]           elig_s;
  logic [NREQ-1:0]           gnt_s;
  logic [NREQ-1:0]           retire_vec_s;
  logic [$clog2(NREQ)-1:0]   gnt_id_s;
  logic                      gnt_any_s;
  logic [TAGW-1:0]           win_tag_s;

  // The whole pipe advances together unless a result is waiting on writeback.
  assign en_s      = ~st_r[LAT-1].v | bus.res_ready;
  assign retire_s  = st_r[LAT-1].v & bus.res_ready;
  assign win_tag_s = bus.req_tag[gnt_id_s];

  // Thread eligibility and per-thread retire decode.
  always_comb begin
    elig_s       = '0;
    retire_vec_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i]       = bus.req_valid[i] & ~bus.flush[i] & (cnt_r[i] < CW'(MAXIF));
      retire_vec_s[i] = retire_s & (st_r[LAT-1].tid == valu_tid_t'(i));
    end
  end

  rfphoenix_rr_arb #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (en_s & rst),
    .req     (elig_s),
    .gnt     (gnt_s),
    .gnt_id  (gnt_id_s),
    .gnt_any (gnt_any_s)
  );

  // Credit update: flush zeroes, grant and retire in the same cycle cancel.
  always_comb begin
    cnt_s = cnt_r;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.flush[i]) begin
        cnt_s[i] = CW'(0);
      end else if (gnt_s[i] && !retire_vec_s[i]) begin
        cnt_s[i] = cnt_r[i] + CW'(1);
      end else if (!gnt_s[i] && retire_vec_s[i]) begin
        cnt_s[i] = cnt_r[i] - CW'(1);
      end else begin
        cnt_s[i] = cnt_r[i];
      end
    end
  end

  // Rigid shift on en (bubbles kept), then kill every op of a flushed thread
  // wherever it lands, whether or not the pipe moved.
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      st_s[k] = st_r[k];
    end
    if (en_s) begin
      st_s[0].v    = gnt_any_s;
      st_s[0].tid  = gnt_id_s;
      st_s[0].tag  = win_tag_s;
      st_s[0].ir   = bus.req_ir[gnt_id_s];
      st_s[0].prc  = bus.req_prc[gnt_id_s];
      st_s[0].data = '0;
      st_s[1]      = st_r[0];
      st_s[1].data = bus.alu_o;
      for (int k = 2; k < LAT; k++) begin
        st_s[k] = st_r[k-1];
      end
    end else begin
      st_s[0] = st_r[0];
    end
    for (int k = 0; k < LAT; k++) begin
      if (bus.flush[st_s[k].tid]) begin
        st_s[k].v = 1'b0;
      end else begin
        st_s[k].v = st_s[k].v;
      end
    end
  end

  // Stage registers; reset clears data too so nothing downstream sees X.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) begin
        st_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LAT; k++) begin
        st_r[k] <= st_s[k];
      end
    end
  end

  // Per-thread in-flight credit counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign bus.req_ready = gnt_s;
  assign bus.alu_ir    = st_r[0].ir;
  assign bus.alu_prc   = st_r[0].prc;
  assign bus.alu_tid   = st_r[0].tid;
  assign bus.res_valid = st_r[LAT-1].v;
  assign bus.res_tid   = st_r[LAT-1].tid;
  assign bus.res_tag   = st_r[LAT-1].tag;
  assign bus.res_o     = st_r[LAT-1].data;

  rfphoenix_valu_sched_chk #(.NREQ(NREQ), .MAXIF(MAXIF), .CW(CW)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt_r),
    .gnt    (gnt_s),
    .retire (retire_vec_s),
    .flush  (bus.flush)
  );

endmodule

// File: tb/tb_rfphoenix_valu_sched.sv
// Bench for the shared vector-ALU scheduler: randomized operands against an
// op-queue reference model of grant order, latency, credits and flush.
module tb_rfphoenix_valu_sched;
  import rfphoenix_valu_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int MAXIF = 2;
  localparam int TAGW  = 6;
  localparam int OBSW  = NREQ + 1 + VALU_TIDW + TAGW + VALU_DW + 2 * NREQ;

  typedef struct {
    int            tid;
    logic [TAGW-1:0] tag;
    vector_value_t data;
    int            stage;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rfphoenix_valu_sched_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  rfphoenix_valu_sched #(.NREQ(NREQ), .LAT(LAT), .MAXIF(MAXIF), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in ALU: any fixed function of its inputs that differs per thread.
  function automatic vector_value_t alu_ref(input instruction_t ir, input prec_t prc, input valu_tid_t tid);
    return {ir, ir ^ 40'h5AC3960FE1, 22'(prc) ^ 22'h2A5A5A, 26'(tid) + 26'h1555555};
  endfunction

  assign bus.alu_o = alu_ref(bus.alu_ir, bus.alu_prc, bus.alu_tid);

  op_t             q[$];
  int              rr;
  int              checks;
  int              passes;
  int              force_tag;
  logic [OBSW-1:0] obs_v, exp_v;
  logic [NREQ-1:0] obs_gnt;
  logic            obs_rv;
  logic [1:0]      obs_rtid;
  logic [TAGW-1:0] obs_rtag;
  logic [7:0]      obs_cnt;

  function automatic int model_cnt(input int t);
    int n = 0;
    foreach (q[j]) if (q[j].tid == t) n++;
    return n;
  endfunction

  // Drive one cycle, sample DUT and model prediction, then advance the model.
  task automatic step(input logic [NREQ-1:0] v, input logic rdy, input logic [NREQ-1:0] fl, input logic r);
    logic head_v, en, found;
    int win;
    logic [NREQ-1:0] gnt;
    logic [2*NREQ-1:0] cnts;
    logic [VALU_TIDW+TAGW+VALU_DW-1:0] hd, hd_obs;
    bus.req_valid = v;
    bus.res_ready = rdy;
    bus.flush     = fl;
    rst           = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ir[i]  = instruction_t'({$urandom(), $urandom()});
      bus.req_prc[i] = prec_t'($urandom_range(3, 0));
      bus.req_tag[i] = (force_tag >= 0) ? TAGW'(force_tag) : TAGW'($urandom());
    end
    #1;
    head_v = (q.size() > 0) && (q[0].stage == LAT - 1);
    en     = !head_v || rdy;
    gnt    = '0;
    found  = 1'b0;
    win    = 0;
    for (int k = 0; k < NREQ; k++) begin
      int t;
      t = (rr + k) % NREQ;
      if (r && en && !found && v[t] && !fl[t] && model_cnt(t) < MAXIF) begin
        gnt[t] = 1'b1;
        win    = t;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) cnts[2*i +: 2] = 2'(model_cnt(i));
    if (head_v) hd = {valu_tid_t'(q[0].tid), q[0].tag, q[0].data};
    else        hd = '0;
    exp_v = {gnt, head_v, hd, cnts};
    if (bus.res_valid) hd_obs = {bus.res_tid, bus.res_tag, bus.res_o};
    else               hd_obs = '0;
    obs_gnt  = bus.req_ready;
    obs_rv   = bus.res_valid;
    obs_rtid = bus.res_tid;
    obs_rtag = bus.res_tag;
    obs_cnt  = dut.cnt_r;
    obs_v    = {bus.req_ready, bus.res_valid, hd_obs, obs_cnt};
    if (!r) begin
      q.delete();
      rr = 0;
    end else begin
      if (head_v && rdy) void'(q.pop_front());
      if (en) foreach (q[j]) q[j].stage++;
      for (int j = q.size() - 1; j >= 0; j--) if (fl[q[j].tid]) q.delete(j);
      if (found) begin
        q.push_back('{tid: win, tag: bus.req_tag[win],
                      data: alu_ref(bus.req_ir[win], bus.req_prc[win], valu_tid_t'(win)), stage: 0});
        rr = (win + 1) % NREQ;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_reset();
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step(4'b0000, 1'b1, 4'b0000, (n == 2) ? 1'b1 : 1'b0);
      if (obs_v !== exp_v) $display("FAIL reset: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
    end
  endtask

  task automatic test_single();
    force_tag = 5;
    for (int n = 0; n < 6; n++) begin
      step((n == 0) ? 4'b0100 : 4'b0000, 1'b1, 4'b0000, 1'b1);
      if (obs_v !== exp_v) $display("FAIL single: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
      if (n == 0) begin
        if (obs_gnt !== 4'b0100) $display("FAIL single_grant: got %b want 0100", obs_gnt); else passes++;
        checks++;
      end
      if (n == 3) begin
        if ({obs_rv, obs_rtid, obs_rtag} !== {1'b1, 2'd2, 6'd5})
          $display("FAIL single_latency: got v=%b tid=%0d tag=%0d want v=1 tid=2 tag=5", obs_rv, obs_rtid, obs_rtag);
        else passes++;
        checks++;
      end
    end
    force_tag = -1;
  endtask

  task automatic test_round_robin();
    for (int n = 0; n < 12; n++) begin
      step(4'b1111, 1'b1, 4'b0000, 1'b1);
      if (obs_v !== exp_v) $display("FAIL round_robin: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
      if ($countones(obs_gnt) != 1) $display("FAIL rr_onehot: got %b want one grant", obs_gnt); else passes++;
      checks++;
    end
  endtask

  task automatic test_stall();
    idle(4);
    for (int n = 0; n < 10; n++) begin
      step(4'b0001, 1'b0, 4'b0000, 1'b1);
      if (obs_v !== exp_v) $display("FAIL stall: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
    end
    if ({obs_gnt, obs_rv} !== {4'b0000, 1'b1}) $display("FAIL stall_credit: got gnt=%b v=%b want 0000 1", obs_gnt, obs_rv);
    else passes++;
    checks++;
    for (int n = 0; n < 6; n++) begin
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      if (obs_v !== exp_v) $display("FAIL stall_drain: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
    end
  endtask

  task automatic test_flush();
    idle(4);
    for (int n = 0; n < 8; n++) begin
      step((n < 3) ? 4'b1010 : 4'b1000, 1'b1, (n == 2) ? 4'b0010 : 4'b0000, 1'b1);
      if (obs_v !== exp_v) $display("FAIL flush: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
      if (n == 2) begin
        if (obs_gnt[1] !== 1'b0) $display("FAIL flush_grant: got %b want 0", obs_gnt[1]); else passes++;
        checks++;
      end
      if (n > 2) begin
        if (obs_rv === 1'b1 && obs_rtid === 2'd1) $display("FAIL flush_leak: got tid=1 result want none");
        else passes++;
        checks++;
      end
    end
  endtask

  task automatic test_flush_retire();
    idle(4);
    for (int n = 0; n < 6; n++) begin
      step((n < 2) ? 4'b0010 : 4'b0000, (n >= 3) ? 1'b1 : 1'b0, (n == 3) ? 4'b0010 : 4'b0000, 1'b1);
      if (obs_v !== exp_v) $display("FAIL flush_retire: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
      if (n == 3) begin
        if ({obs_rv, obs_rtid} !== {1'b1, 2'd1}) $display("FAIL fr_head: got v=%b tid=%0d want v=1 tid=1", obs_rv, obs_rtid);
        else passes++;
        checks++;
      end
      if (n == 4) begin
        if ({obs_rv, obs_cnt[3:2]} !== 3'b000) $display("FAIL fr_after: got v=%b cnt1=%0d want 0 0", obs_rv, obs_cnt[3:2]);
        else passes++;
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(4);
    for (int n = 0; n < 7; n++) begin
      step(4'b1111, 1'b1, 4'b0000, (n == 4) ? 1'b0 : 1'b1);
      if (obs_v !== exp_v) $display("FAIL reset_mid: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
      if (n == 5) begin
        if ({obs_gnt, obs_rv, obs_cnt} !== {4'b0001, 1'b0, 8'h00})
          $display("FAIL reset_mid_after: got gnt=%b v=%b cnt=%h want 0001 0 00", obs_gnt, obs_rv, obs_cnt);
        else passes++;
        checks++;
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] fl;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) fl[i] = ($urandom_range(15, 0) == 0);
      step(NREQ'($urandom()), ($urandom_range(3, 0) != 0), fl, ($urandom_range(99, 0) != 0));
      if (obs_v !== exp_v) $display("FAIL random: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
    end
  endtask

  initial begin
    checks        = 0;
    passes        = 0;
    rr            = 0;
    force_tag     = -1;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.flush     = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ir[i]  = '0;
      bus.req_prc[i] = PRC8;
      bus.req_tag[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_flush();
    test_flush_retire();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
